// File: rtl/tt_um_fifo.sv
`default_nettype none
// ============================================================================
// tt_um_fifo : 8-bit x 16-entry synchronous FIFO packaged as a TinyTapeout tile
// Rev 1.0
// ============================================================================
module tt_um_fifo #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW + 1)'(AF_LEVEL);
  localparam logic [AW:0] AE_CNT   = (AW + 1)'(AE_LEVEL);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic [7:0]    rd_data;
  logic          overflow;
  logic          underflow;

  logic wr_en;
  logic rd_en;
  logic full;
  logic empty;
  logic almost_full;
  logic almost_empty;
  logic rd_acc;
  logic wr_acc;
  logic unused_ok;

  assign wr_en     = uio_in[0];
  assign rd_en     = uio_in[1];
  assign unused_ok = &{1'b0, uio_in[7:2]};

  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // A write into a full FIFO is still accepted when a read frees a slot the same edge.
  assign rd_acc = ena & rd_en & ~empty;
  assign wr_acc = ena & wr_en & (~full | rd_acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      rd_data   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_acc) begin
        rptr    <= rptr + 1'b1;
        rd_data <= mem[rptr];
      end
      if (wr_acc && !rd_acc) begin
        count <= count + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        count <= count - 1'b1;
      end
      if (ena && wr_en && !wr_acc) begin
        overflow <= 1'b1;
      end
      if (ena && rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr] <= ui_in;
    end
  end

  assign uo_out  = rd_data;
  assign uio_out = {underflow, overflow, almost_empty, almost_full, empty, full, 2'b00};
  assign uio_oe  = 8'b1111_1100;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_fifo.sv
`default_nettype none
// ============================================================================
// tb_tt_um_fifo : directed + random stimulus against a queue-based FIFO model
// Rev 1.0
// ============================================================================
module tb_tt_um_fifo;

  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;
  logic       clk;
  logic       rst_n;

  tt_um_fifo dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_ovf;
  logic       m_udf;

  function automatic void model_reset();
    q.delete();
    m_dout = 8'h00;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endfunction

  function automatic logic [7:0] exp_flags();
    int n;
    n = q.size();
    return {m_udf, m_ovf, (n <= 2), (n >= 14), (n == 0), (n == 16), 2'b00};
  endfunction

  task automatic check(input string tag);
    logic [7:0] ef;
    ef = exp_flags();
    checks++;
    assert (uo_out === m_dout) else begin
      errors++;
      $error("FAIL %s uo_out observed=%h expected=%h", tag, uo_out, m_dout);
    end
    checks++;
    assert (uio_out === ef) else begin
      errors++;
      $error("FAIL %s uio_out observed=%b expected=%b", tag, uio_out, ef);
    end
  endtask

  // One clock: drive on the falling edge, advance the model at the rising edge, check 1ns later.
  task automatic step(input logic e, input logic w, input logic r, input logic [7:0] d,
                      input string tag);
    logic rd_a;
    logic wr_a;
    @(negedge clk);
    ena    = e;
    uio_in = {6'b0, r, w};
    ui_in  = d;
    @(posedge clk);
    rd_a = e && r && (q.size() != 0);
    wr_a = e && w && ((q.size() < 16) || rd_a);
    if (e && w && !wr_a) m_ovf = 1'b1;
    if (e && r && (q.size() == 0)) m_udf = 1'b1;
    if (rd_a) m_dout = q.pop_front();
    if (wr_a) q.push_back(d);
    #1;
    check(tag);
  endtask

  initial begin
    model_reset();
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h08;
    uio_in = 8'h00;
    #12;
    check("reset");
    checks++;
    assert (uio_oe === 8'hFC) else begin
      errors++;
      $error("FAIL uio_oe observed=%h expected=%h", uio_oe, 8'hFC);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // single write then read
    step(1'b1, 1'b1, 1'b0, 8'h08, "single_wr");
    step(1'b1, 1'b0, 1'b1, 8'h00, "single_rd");
    step(1'b1, 1'b0, 1'b0, 8'h00, "single_idle");

    // fill, overflow, drain
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 8'(i), "fill");
    step(1'b1, 1'b1, 1'b0, 8'hAA, "overflow");
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 8'h00, "drain");

    // underflow and enable gating
    step(1'b1, 1'b0, 1'b1, 8'h00, "underflow");
    step(1'b0, 1'b1, 1'b0, 8'h55, "ena_gate_wr");
    step(1'b0, 1'b0, 1'b1, 8'h00, "ena_gate_rd");

    // full with simultaneous read+write across pointer wrap
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h40 + i), "refill");
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 8'(8'h80 + i), "rw_full");
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 8'h00, "drain_wrap");
    step(1'b1, 1'b1, 1'b1, 8'h77, "rw_empty");
    step(1'b1, 1'b0, 1'b1, 8'h00, "rw_empty_rd");

    // asynchronous reset between edges with 5 entries stored
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i), "pre_rst");
    @(negedge clk);
    uio_in = 8'h00;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst");
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1, 8'h00, "post_rst_rd");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), 8'($urandom), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
